// File: rtl/serial_sub_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter must hold WIDTH itself, reached on the final RUN edge.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/full_subtractor_cell.sv
// One-bit combinational full subtractor: d = a - b - bin, with borrow out.
module full_subtractor_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one bit per clock, LSB first, parallel load and result.
// Handshake: start is sampled only in IDLE; done pulses one cycle when diff/bout update.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             bin_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] r_sh;
  logic [WIDTH-1:0] r_next;
  logic [WIDTH-1:0] d_msb;
  logic             borrow;
  logic             cell_d;
  logic             cell_bout;
  logic             last_bit;

  full_subtractor_cell u_cell (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .bin  (borrow),
    .d    (cell_d),
    .bout (cell_bout)
  );

  assign last_bit = (cnt == LAST);

  // New difference bit enters at the MSB; works for WIDTH=1 as well.
  always_comb begin
    d_msb            = '0;
    d_msb[WIDTH-1]   = cell_d;
    r_next           = (r_sh >> 1) | d_msb;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_bit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      a_sh   <= '0;
      b_sh   <= '0;
      r_sh   <= '0;
      borrow <= 1'b0;
      diff   <= '0;
      bout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh   <= a_in;
            b_sh   <= b_in;
            borrow <= bin_in;
            cnt    <= '0;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          r_sh   <= r_next;
          borrow <= cell_bout;
          cnt    <= cnt + CW'(1);
          if (last_bit) begin
            diff <= r_next;
            bout <= cell_bout;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor at WIDTH 8, 4 and 1 against an arithmetic reference.
module tb_serial_subtractor;

  logic clk;
  logic rst_n;

  logic       start8, bin8, busy8, done8, bout8;
  logic [7:0] a8, b8, diff8;
  logic       start4, bin4, busy4, done4, bout4;
  logic [3:0] a4, b4, diff4;
  logic       start1, bin1, busy1, done1, bout1;
  logic [0:0] a1, b1, diff1;

  int errors = 0;
  int checks = 0;
  int sel    = 8;

  logic       obs_busy, obs_done, obs_bout;
  logic [7:0] obs_diff;

  logic [8:0] exp_q[$];

  serial_subtractor #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a_in(a8), .b_in(b8), .bin_in(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
  );
  serial_subtractor #(.WIDTH(4)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a_in(a4), .b_in(b4), .bin_in(bin4),
    .busy(busy4), .done(done4), .diff(diff4), .bout(bout4)
  );
  serial_subtractor #(.WIDTH(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a_in(a1), .b_in(b1), .bin_in(bin1),
    .busy(busy1), .done(done1), .diff(diff1), .bout(bout1)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    obs_busy = busy8;
    obs_done = done8;
    obs_bout = bout8;
    obs_diff = diff8;
    case (sel)
      4: begin obs_busy = busy4; obs_done = done4; obs_bout = bout4; obs_diff = {4'd0, diff4}; end
      1: begin obs_busy = busy1; obs_done = done1; obs_bout = bout1; obs_diff = {7'd0, diff1}; end
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver
  task automatic drive(input int w, input logic st, input logic [7:0] a, input logic [7:0] b,
                       input logic bn);
    case (w)
      8: begin start8 = st; a8 = a; b8 = b; bin8 = bn; end
      4: begin start4 = st; a4 = a[3:0]; b4 = b[3:0]; bin4 = bn; end
      default: begin start1 = st; a1 = a[0:0]; b1 = b[0:0]; bin1 = bn; end
    endcase
  endtask

  // reference model: plain modular arithmetic
  function automatic logic [8:0] ref_result(input int w, input int a, input int b, input int bn);
    int mask;
    int d;
    logic br;
    mask = (1 << w) - 1;
    d    = (a - b - bn) & mask;
    br   = (a < b + bn);
    return {br, d[7:0]};
  endfunction

  // One full operation started at the next edge; checks latency, busy, result, and idle after.
  task automatic run_op(input int w, input int a, input int b, input int bn);
    logic [8:0] e;
    sel = w;
    drive(w, 1'b1, a[7:0], b[7:0], bn[0]);
    exp_q.push_back(ref_result(w, a, b, bn));
    tick();  // E0
    drive(w, 1'b0, $urandom, $urandom, $urandom_range(0, 1) == 1);
    for (int k = 1; k <= w; k++) begin
      tick();
      if (k < w) begin
        check("done_early", obs_done, 1'b0);
        check("busy_run", obs_busy, 1'b1);
      end
    end
    check("done_at_w", obs_done, 1'b1);
    check("busy_done", obs_busy, 1'b1);
    e = exp_q.pop_front();
    check($sformatf("diff w%0d a%0d b%0d c%0d", w, a, b, bn), obs_diff, e[7:0]);
    check($sformatf("bout w%0d a%0d b%0d c%0d", w, a, b, bn), obs_bout, e[8]);
    tick();  // E(w+1)
    check("done_fall", obs_done, 1'b0);
    check("busy_fall", obs_busy, 1'b0);
    check("diff_hold", obs_diff, e[7:0]);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(8, 1'b0, 8'd0, 8'd0, 1'b0);
    drive(4, 1'b0, 8'd0, 8'd0, 1'b0);
    drive(1, 1'b0, 8'd0, 8'd0, 1'b0);
    #3;
    check("rst_busy", busy8, 1'b0);
    check("rst_done", done8, 1'b0);
    check("rst_diff", diff8, 8'd0);
    check("rst_bout", bout8, 1'b0);
    #20;
    rst_n = 1'b1;
    tick();

    // directed cases
    run_op(8, 200, 55, 0);
    run_op(8, 0, 1, 0);
    run_op(8, 5, 5, 1);
    run_op(8, 255, 0, 0);

    // start pulsed at E3 and E8 must be ignored
    sel = 8;
    drive(8, 1'b1, 8'd100, 8'd1, 1'b0);
    tick();  // E0
    drive(8, 1'b0, 8'd7, 8'd9, 1'b1);
    for (int k = 1; k <= 9; k++) begin
      if (k == 3 || k == 8) drive(8, 1'b1, 8'd50, 8'd60, 1'b1);
      tick();
      drive(8, 1'b0, 8'd50, 8'd60, 1'b1);
      if (k == 8) begin
        check("ign_done", done8, 1'b1);
        check("ign_diff", diff8, 8'd99);
        check("ign_bout", bout8, 1'b0);
      end else begin
        check($sformatf("ign_nodone_e%0d", k), done8, 1'b0);
      end
    end
    check("ign_busy_fall", busy8, 1'b0);
    run_op(8, 33, 77, 1);  // fresh start accepted at E10

    // reset mid-operation
    drive(8, 1'b1, 8'd0, 8'd255, 1'b1);
    tick();  // E0
    drive(8, 1'b0, 8'd0, 8'd0, 1'b0);
    for (int k = 1; k <= 4; k++) tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy8, 1'b0);
    check("mid_rst_done", done8, 1'b0);
    check("mid_rst_diff", diff8, 8'd0);
    check("mid_rst_bout", bout8, 1'b0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("abort_no_done", done8, 1'b0);
    end
    run_op(8, 10, 3, 0);

    // random WIDTH=8 operations, back-to-back
    for (int i = 0; i < 40; i++)
      run_op(8, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 1));

    // exhaustive small widths, back-to-back at the earliest accepting edge
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 2; c++)
          run_op(4, a, b, c);
    for (int a = 0; a < 2; a++)
      for (int b = 0; b < 2; b++)
        for (int c = 0; c < 2; c++)
          run_op(1, a, b, c);

    check("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
